// File: rtl/stage_timer_pkg.sv
// Shared definitions for the game stage timer: game state codes, display
// constants and the timer FSM encoding.
package stage_timer_pkg;

    localparam logic [3:0]  ST_MENU          = 4'd0;
    localparam logic [3:0]  ST_STAGE1        = 4'd3;
    localparam logic [3:0]  ST_STAGE2        = 4'd4;
    localparam logic [3:0]  ST_WIN           = 4'd6;

    localparam logic [15:0] RUN_MASK_DEFAULT = 16'h0018;

    localparam logic [3:0]  BCD_DASH         = 4'hA;
    localparam logic [15:0] NUMS_DASH        = {4{BCD_DASH}};
    localparam logic [15:0] BCD_TIME_MAX     = 16'h9959;

    typedef enum logic [1:0] {
        TMR_IDLE,
        TMR_RUN,
        TMR_PAUSE,
        TMR_DONE
    } tmr_state_e;

endpackage

// File: rtl/stage_timer_if.sv
// Bundle between game_play/SevenSegment and the stage timer.
interface stage_timer_if;

    logic [3:0]  state;
    logic        show_best;
    logic [15:0] nums;
    logic        running;
    logic        new_record;
    logic        saturated;

    modport master (
        output state,
        output show_best,
        input  nums,
        input  running,
        input  new_record,
        input  saturated
    );

    modport slave (
        input  state,
        input  show_best,
        output nums,
        output running,
        output new_record,
        output saturated
    );

endinterface

// File: rtl/stage_timer_bcd_sec_counter.sv
// MM:SS BCD incrementer that pins at 99:59 and flags saturation until cleared.
module bcd_sec_counter
    import stage_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] value,
    output logic        saturated
);

    logic [3:0] min_hi_q, min_hi_d;
    logic [3:0] min_lo_q, min_lo_d;
    logic [3:0] sec_hi_q, sec_hi_d;
    logic [3:0] sec_lo_q, sec_lo_d;
    logic       sat_q, sat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_hi_q <= '0;
            min_lo_q <= '0;
            sec_hi_q <= '0;
            sec_lo_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            min_hi_q <= min_hi_d;
            min_lo_q <= min_lo_d;
            sec_hi_q <= sec_hi_d;
            sec_lo_q <= sec_lo_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        min_hi_d = min_hi_q;
        min_lo_d = min_lo_q;
        sec_hi_d = sec_hi_q;
        sec_lo_d = sec_lo_q;
        sat_d    = sat_q;
        if (clr) begin
            min_hi_d = '0;
            min_lo_d = '0;
            sec_hi_d = '0;
            sec_lo_d = '0;
            sat_d    = 1'b0;
        end else if (inc) begin
            // 99:59 is the only value whose carry would ripple out of min_hi.
            if ({min_hi_q, min_lo_q, sec_hi_q, sec_lo_q} == BCD_TIME_MAX) begin
                sat_d = 1'b1;
            end else if (sec_lo_q != 4'd9) begin
                sec_lo_d = sec_lo_q + 4'd1;
            end else begin
                sec_lo_d = '0;
                if (sec_hi_q != 4'd5) begin
                    sec_hi_d = sec_hi_q + 4'd1;
                end else begin
                    sec_hi_d = '0;
                    if (min_lo_q != 4'd9) begin
                        min_lo_d = min_lo_q + 4'd1;
                    end else begin
                        min_lo_d = '0;
                        min_hi_d = min_hi_q + 4'd1;
                    end
                end
            end
        end
    end

    assign value     = {min_hi_q, min_lo_q, sec_hi_q, sec_lo_q};
    assign saturated = sat_q;

endmodule

// File: rtl/stage_timer.sv
// Elapsed-play stopwatch: follows the game state, counts MM:SS while playing,
// freezes on a win and keeps the best time for the seven-segment display.
module stage_timer
    import stage_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter logic [15:0] RUN_MASK    = RUN_MASK_DEFAULT,
    parameter logic [3:0]  CLEAR_STATE = ST_MENU,
    parameter logic [3:0]  WIN_STATE   = ST_WIN
) (
    input  logic          clk,
    input  logic          rst_n,
    stage_timer_if.slave  bus
);

    localparam int unsigned     PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);

    tmr_state_e     fsm_q, fsm_d;
    logic [3:0]     state_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic [15:0]    best_q, best_d;
    logic           best_valid_q, best_valid_d;
    logic           new_record_q, new_record_d;

    logic           clear_entry;
    logic           win_entry;
    logic           run_state;
    logic           tick;
    logic [15:0]    cur;
    logic           cur_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= TMR_IDLE;
            state_q      <= CLEAR_STATE;
            presc_q      <= '0;
            best_q       <= BCD_TIME_MAX;
            best_valid_q <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= bus.state;
            presc_q      <= presc_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_record_q <= new_record_d;
        end
    end

    always_comb begin
        clear_entry = (bus.state == CLEAR_STATE) && (bus.state != state_q);
        win_entry   = (bus.state == WIN_STATE) && (bus.state != state_q);
        run_state   = RUN_MASK[bus.state];

        fsm_d = fsm_q;
        if (clear_entry) begin
            fsm_d = TMR_IDLE;
        end else begin
            case (fsm_q)
                TMR_IDLE: begin
                    if (run_state) fsm_d = TMR_RUN;
                end
                TMR_RUN, TMR_PAUSE: begin
                    if (win_entry)      fsm_d = TMR_DONE;
                    else if (run_state) fsm_d = TMR_RUN;
                    else                fsm_d = TMR_PAUSE;
                end
                TMR_DONE: fsm_d = TMR_DONE;
                default:  fsm_d = TMR_IDLE;
            endcase
        end
    end

    // The prescaler advances on every edge that leaves the FSM in RUN, so the
    // DONE-entry cycle never ticks and the frozen time is the pre-tick value.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (clear_entry) begin
            presc_d = '0;
        end else if (fsm_d == TMR_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_record_d = 1'b0;
        if ((fsm_d == TMR_DONE) && (fsm_q != TMR_DONE)
            && (!best_valid_q || (cur < best_q))) begin
            best_d       = cur;
            best_valid_d = 1'b1;
            new_record_d = 1'b1;
        end
    end

    bcd_sec_counter u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (tick),
        .clr       (clear_entry),
        .value     (cur),
        .saturated (cur_sat)
    );

    always_comb begin
        if (bus.show_best) bus.nums = best_valid_q ? best_q : NUMS_DASH;
        else               bus.nums = cur;
    end

    assign bus.running    = (fsm_q == TMR_RUN);
    assign bus.new_record = new_record_q;
    assign bus.saturated  = cur_sat;

endmodule
